// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter.
//   bcd2bin_state_t : converter FSM states
//   DIGIT_W, NUM_DIGITS, SHIFT_STEPS, MAX_DIGIT, ADJ_THRESH, ADJ_SUB : constants
//   has_bad_digit() : flags a packed BCD word containing any nibble > 9
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd2bin_state_t;

  localparam int DIGIT_W     = 4;
  localparam int NUM_DIGITS  = 4;
  localparam int BCD_W       = DIGIT_W * NUM_DIGITS;
  localparam int SHIFT_STEPS = 16;
  localparam int CNT_W       = 5;

  localparam logic [DIGIT_W-1:0] MAX_DIGIT  = 4'd9;
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd8;
  localparam logic [DIGIT_W-1:0] ADJ_SUB    = 4'd3;

  function automatic logic has_bad_digit(input logic [BCD_W-1:0] bcd);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[i*DIGIT_W +: DIGIT_W] > MAX_DIGIT) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble correction for one BCD nibble.
//   digit    : nibble after the right shift
//   adjusted : digit - 3 when digit >= 8, otherwise digit unchanged
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adjusted
);

  always_comb begin
    adjusted = digit;
    if (digit >= ADJ_THRESH) adjusted = digit - ADJ_SUB;
  end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one shift per clock).
//   clk            : system clock, rising edge
//   rst            : asynchronous active-high reset
//   start          : conversion request, sampled only in IDLE
//   unidades_input / decenas_input / centenas_input / millares_input : BCD digits
//   numero_output  : binary result, held until the next completion
//   busy           : conversion in progress
//   ready          : one-cycle completion pulse
//   error          : last accepted request contained a digit > 9
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int BIN_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DIGIT_W-1:0] unidades_input,
  input  logic [DIGIT_W-1:0] decenas_input,
  input  logic [DIGIT_W-1:0] centenas_input,
  input  logic [DIGIT_W-1:0] millares_input,
  output logic [BIN_W-1:0]   numero_output,
  output logic               busy,
  output logic               ready,
  output logic               error
);

  bcd2bin_state_t state_q, state_d;

  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bin_q;
  logic [CNT_W-1:0] count_q;

  logic [BCD_W-1:0] digits_in;
  logic             digits_bad;
  logic [BCD_W-1:0] bcd_shift;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bin_shift;

  assign digits_in  = {millares_input, centenas_input, decenas_input, unidades_input};
  assign digits_bad = has_bad_digit(digits_in);

  // One reverse double-dabble step: shift {bcd,bin} right, then correct nibbles.
  assign bcd_shift = {1'b0, bcd_q[BCD_W-1:1]};
  assign bin_shift = {bcd_q[0], bin_q[BCD_W-1:1]};

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit    (bcd_shift[g*DIGIT_W +: DIGIT_W]),
      .adjusted (bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // SHIFT performs steps 1..15; the 16th step is taken on the DONE exit edge
  // together with the registered result and ready pulse. That places ready at
  // E16 and returns to IDLE in time to accept a held start at E17.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = digits_bad ? DONE : SHIFT;
      SHIFT:   if (count_q == CNT_W'(SHIFT_STEPS - 2)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q         <= '0;
      bin_q         <= '0;
      count_q       <= '0;
      numero_output <= '0;
      busy          <= 1'b0;
      ready         <= 1'b0;
      error         <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bcd_q   <= digits_in;
            bin_q   <= '0;
            count_q <= '0;
            error   <= digits_bad;
            busy    <= ~digits_bad;
            if (digits_bad) numero_output <= '0;
          end
        end
        SHIFT: begin
          bcd_q   <= bcd_adj;
          bin_q   <= bin_shift;
          count_q <= count_q + 1'b1;
        end
        DONE: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          // Rejected requests skip the final step and keep numero_output at 0.
          if (!error) begin
            bcd_q         <= bcd_adj;
            bin_q         <= bin_shift;
            count_q       <= count_q + 1'b1;
            numero_output <= bin_shift[BIN_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  unidades, decenas, centenas, millares;
  logic [15:0] numero;
  logic        busy, ready, error;

  int vectors    = 0;
  int miscompares = 0;

  bcd_to_bin #(.BIN_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .unidades_input (unidades),
    .decenas_input  (decenas),
    .centenas_input (centenas),
    .millares_input (millares),
    .numero_output  (numero),
    .busy           (busy),
    .ready          (ready),
    .error          (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_digits(input logic [15:0] d);
    millares = d[15:12];
    centenas = d[11:8];
    decenas  = d[7:4];
    unidades = d[3:0];
  endtask

  logic [15:0] seq_digits [4];
  logic [15:0] seq_result [4];
  logic [15:0] prev;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    set_digits(16'h0000);

    // Reset for two cycles.
    step();
    step();
    check("rst_numero", numero, 0);
    check("rst_busy",   busy,   0);
    check("rst_ready",  ready,  0);
    check("rst_error",  error,  0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("idle_ready", ready, 0);
    check("idle_busy",  busy,  0);

    // Single conversion 1234.
    set_digits(16'h1234);
    start = 1'b1;
    step();                       // E0
    start = 1'b0;
    check("c1234_busy_e0", busy, 1);
    for (int i = 1; i <= 15; i++) begin
      step();
      check("c1234_busy",  busy,  1);
      check("c1234_ready", ready, 0);
    end
    step();                       // E16
    check("c1234_ready_e16", ready,  1);
    check("c1234_busy_e16",  busy,   0);
    check("c1234_value",     numero, 16'd1234);
    step();                       // E17
    check("c1234_ready_e17", ready,  0);
    check("c1234_hold",      numero, 16'd1234);

    // Back-to-back with start held high; digits change right after each accept.
    seq_digits[0] = 16'h5678; seq_result[0] = 16'd5678;
    seq_digits[1] = 16'h0910; seq_result[1] = 16'd910;
    seq_digits[2] = 16'h9999; seq_result[2] = 16'd9999;
    seq_digits[3] = 16'h0000; seq_result[3] = 16'd0;
    prev = 16'd1234;
    set_digits(seq_digits[0]);
    start = 1'b1;
    step();                       // first E0
    check("b2b_busy_start", busy, 1);
    for (int k = 0; k < 4; k++) begin
      if (k < 3) set_digits(seq_digits[k+1]);
      else       start = 1'b0;
      for (int i = 1; i <= 15; i++) begin
        step();
        check("b2b_ready_low", ready,  0);
        check("b2b_held",      numero, prev);
      end
      step();
      check("b2b_ready_pulse", ready,  1);
      check("b2b_value",       numero, seq_result[k]);
      prev = seq_result[k];
      step();
      check("b2b_ready_fall", ready, 0);
      check("b2b_busy_next",  busy,  (k < 3) ? 1 : 0);
    end

    // Invalid tens digit: immediate DONE with error.
    set_digits(16'h00A0);
    start = 1'b1;
    step();                       // E0
    start = 1'b0;
    check("err_busy_e0",  busy,  0);
    check("err_ready_e0", ready, 0);
    step();                       // E1
    check("err_ready_e1",  ready,  1);
    check("err_flag_e1",   error,  1);
    check("err_numero_e1", numero, 0);
    check("err_busy_e1",   busy,   0);
    step();
    check("err_ready_e2", ready, 0);
    check("err_flag_held", error, 1);

    // Valid request clears error; result 42.
    set_digits(16'h0042);
    start = 1'b1;
    step();
    start = 1'b0;
    check("v42_error_e0", error, 0);
    check("v42_busy_e0",  busy,  1);
    for (int i = 1; i <= 15; i++) step();
    step();
    check("v42_ready", ready,  1);
    check("v42_value", numero, 16'd42);
    step();

    // Starts during a conversion are ignored.
    set_digits(16'h1234);
    start = 1'b1;
    step();                       // E0
    start = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 5 || i == 10) begin
        set_digits(16'h8888);
        start = 1'b1;
      end
      step();
      start = 1'b0;
      if (i < 16) check("ign_ready_low", ready, 0);
      else begin
        check("ign_ready_e16", ready,  1);
        check("ign_value",     numero, 16'd1234);
      end
    end
    step();
    check("ign_ready_e17", ready, 0);
    check("ign_no_restart", busy, 0);

    // Asynchronous reset mid-conversion.
    set_digits(16'h5678);
    start = 1'b1;
    step();                       // E0
    start = 1'b0;
    for (int i = 1; i <= 7; i++) step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_numero", numero, 0);
    check("arst_busy",   busy,   0);
    check("arst_ready",  ready,  0);
    check("arst_error",  error,  0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("arst_no_ready", ready, 0);
      check("arst_idle",     busy,  0);
    end

    // Fresh conversion after reset.
    set_digits(16'h0321);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 15; i++) step();
    step();
    check("post_rst_ready", ready,  1);
    check("post_rst_value", numero, 16'd321);
    step();
    check("post_rst_fall", ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
